// File: rtl/odd_parity_serial_tx.sv
// ---------------------------------------------------------------------------
// odd_parity_serial_tx
//
// Serial transmitter that frames a parallel word as:
//   start (0) | data bits LSB first | odd parity bit | stop (1)
// Each serial bit lasts `divisor` clk cycles. The line idles high.
//
// Parameters:
//   width    - data bits per frame (>= 1)
//   divisor  - clk cycles per serial bit (>= 2)
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - synchronous, active-high reset
//   i_data   - parallel word to transmit
//   i_valid  - i_data is presented for transmission
//   i_inject - (only with ODD_PARITY_SERIAL_TX_INJECT_EN) invert the parity
//              bit of the word accepted in the same cycle
//   o_ready  - block can accept a word this cycle (IDLE only)
//   o_tx     - registered serial line output, idle high
//   o_busy   - a frame is in progress (inverse of o_ready)
//
// Optional feature macro: ODD_PARITY_SERIAL_TX_INJECT_EN
//   When defined, adds i_inject for deliberate parity corruption. When not
//   defined, the port is absent and parity is always correct.
// ---------------------------------------------------------------------------
module odd_parity_serial_tx #(
    parameter int width   = 8,
    parameter int divisor = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i_data,
    input  logic             i_valid,
`ifdef ODD_PARITY_SERIAL_TX_INJECT_EN
    input  logic             i_inject,
`endif
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy
);

    // Counter widths; kept at least one bit wide for the degenerate width=1 case.
    localparam int CW = (divisor > 1) ? $clog2(divisor) : 1;
    localparam int BW = (width > 1) ? $clog2(width) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(divisor - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Odd parity bit: makes data plus parity hold an odd number of ones.
    function automatic logic odd_parity(input logic [width-1:0] d);
        return ~(^d);
    endfunction

    state_t            state_r;
    logic [CW-1:0]     cnt_r;     // bit-period counter, 0..divisor-1
    logic [BW-1:0]     bit_idx_r; // index of the data bit currently on the line
    logic [width-1:0]  shift_r;   // remaining data bits, next bit at [0]
    logic              par_r;     // parity bit to send, fixed at acceptance
    logic              tx_r;
    logic              ready_s;
    logic              inject_s;

`ifdef ODD_PARITY_SERIAL_TX_INJECT_EN
    assign inject_s = i_inject;
`else
    assign inject_s = 1'b0;
`endif

    // Ready is a pure decode of the state so it never depends on i_valid.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign o_ready = ready_s;
    assign o_busy  = ~ready_s;
    assign o_tx    = tx_r;

    // Frame sequencer: state, counters, datapath and the registered line value.
    // tx_r is loaded with the value of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= '0;
            shift_r   <= '0;
            par_r     <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                    if (i_valid) begin
                        state_r <= ST_START;
                        shift_r <= i_data;
                        par_r   <= odd_parity(i_data) ^ inject_s;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= '0;
                        bit_idx_r <= '0;
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                    end else begin
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (bit_idx_r == BIT_LAST) begin
                            state_r <= ST_PARITY;
                            tx_r    <= par_r;
                        end else begin
                            bit_idx_r <= bit_idx_r + BW'(1);
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_STOP;
                        tx_r    <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                    tx_r      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_odd_parity_serial_tx
// Directed bench for odd_parity_serial_tx with width=8, divisor=4.
// Outputs are sampled on the falling edge; inputs change just after edges.
// ---------------------------------------------------------------------------
module tb_odd_parity_serial_tx;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         i_inject;
    logic         o_ready;
    logic         o_tx;
    logic         o_busy;

    int tests_run;
    int tests_failed;

    odd_parity_serial_tx #(.width(W), .divisor(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
`ifdef ODD_PARITY_SERIAL_TX_INJECT_EN
        .i_inject(i_inject),
`endif
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         exp_par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Present a word for one acceptance edge (DUT must be idle).
    task automatic send(input logic [W-1:0] d, input logic inj);
        i_data   = d;
        i_inject = inj;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_inject = 1'b0;
    endtask

    // Check all 44 frame cycles following acceptance, then the odd-parity
    // checker over the sampled data+parity bits. Optionally change i_data
    // mid-frame to show it has no effect.
    task automatic check_frame(input logic [W-1:0] d, input logic par,
                               input bit flip, input logic [W-1:0] nd,
                               input logic expect_err);
        logic [10:0] exp;
        int ones;
        logic err;
        exp  = {1'b1, par, d, 1'b0};
        ones = 0;
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < D; c++) begin
                @(negedge clk);
                if (flip && k == 3 && c == 0) i_data = nd;
                chk($sformatf("tx_bit%0d_cyc%0d", k, c), o_tx, exp[k]);
                if (c == 0) begin
                    chk($sformatf("busy_bit%0d", k), o_busy, 1'b1);
                    if (k >= 1 && k <= 9 && o_tx === 1'b1) ones++;
                end
            end
        end
        err = ((ones % 2) == 0);
        chk("parity_checker", err, expect_err);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk({name, "_tx"},    o_tx,    1'b1);
        chk({name, "_ready"}, o_ready, 1'b1);
        chk({name, "_busy"},  o_busy,  1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_inject = 1'b0;

        // Hand-computed odd parity bits.
        vecs[0] = '{8'hA5, 1'b1};
        vecs[1] = '{8'h00, 1'b1};
        vecs[2] = '{8'h01, 1'b0};
        vecs[3] = '{8'hFF, 1'b1};
        vecs[4] = '{8'h80, 1'b0};
        vecs[5] = '{8'h55, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Table-driven single frames, each followed by the idle cycle.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, 1'b0);
            check_frame(vecs[i].data, vecs[i].exp_par, 1'b0, 8'h00, 1'b0);
            check_idle($sformatf("after_vec%0d", i));
        end

        // Back-to-back with i_valid held: 0x12 then 0x34; i_data changes
        // to 0x34 during frame 1. Frame 2 starts right after one idle cycle.
        i_data  = 8'h12;
        i_valid = 1'b1;
        @(posedge clk);
        check_frame(8'h12, 1'b1, 1'b1, 8'h34, 1'b0);
        @(negedge clk);
        chk("b2b_gap_tx",    o_tx,    1'b1);
        chk("b2b_gap_ready", o_ready, 1'b1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        check_frame(8'h34, 1'b0, 1'b0, 8'h00, 1'b0);
        check_idle("after_b2b");

        // Reset during DATA bit 3, then a clean 0x55 frame.
        send(8'hA5, 1'b0);
        repeat (D + 3 * D + 2) @(negedge clk);
        chk("pre_rst_busy", o_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle("mid_rst");
        send(8'h55, 1'b0);
        check_frame(8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
        check_idle("after_rst_frame");

        // rst and i_valid together: reset wins, no word accepted.
        i_data  = 8'hFF;
        i_valid = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        check_idle("rst_vs_valid");
        check_idle("rst_vs_valid2");

`ifdef ODD_PARITY_SERIAL_TX_INJECT_EN
        // Corrupted parity, then a normal frame.
        send(8'hA5, 1'b1);
        check_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        check_idle("after_inject");
        send(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
        check_idle("after_clean");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/odd_parity_serial_tx.md
ODD_PARITY_SERIAL_TX -- requirements
Module: odd_parity_serial_tx

Interface
REQ-001 SHALL have parameter: width, default 8, number of data bits per frame (>=1).
REQ-002 SHALL have parameter: divisor, default 16, clk cycles per serial bit (>=2).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: i_data  input  width  parallel word to transmit.
REQ-006 SHALL have port: i_valid  input  1  i_data is presented for transmission.
REQ-007 SHALL have port: o_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port: o_tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port: o_busy  output  1  a frame is in progress (not IDLE).
REQ-010 SHALL have port, only when ODD_PARITY_SERIAL_TX_INJECT_EN is defined: i_inject  input  1  corrupt parity of the accepted word.

Function
REQ-011 SHALL accept a word on a cycle with i_valid=1 and o_ready=1, latching i_data and its parity in that cycle.
REQ-012 SHALL compute the parity bit as the inverse XOR-reduction of the latched word, so data plus parity holds an odd number of ones.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START on acceptance, START->DATA, DATA->PARITY after bit width-1, PARITY->STOP, STOP->IDLE.
REQ-014 SHALL drive o_tx: 1 in IDLE, 0 in START, data LSB first in DATA, parity bit in PARITY, 1 in STOP.
REQ-015 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly divisor cycles, using a bit-period counter that runs 0..divisor-1 and wraps.
REQ-016 SHALL make o_tx show the start bit on the first cycle after acceptance.
REQ-017 SHALL make a full frame occupy (width+3)*divisor cycles.
REQ-018 SHALL drive o_ready=1 only in IDLE, with o_ready combinational from state (not from i_valid).
REQ-019 SHALL drive o_busy as the inverse of o_ready.
REQ-020 SHALL return to IDLE on the cycle after the last STOP cycle.
REQ-021 SHALL, for back-to-back words, allow the earliest next acceptance on that first IDLE cycle, giving a minimum gap of one idle-high cycle between frames.
REQ-022 SHALL ignore i_valid and i_data while busy; a held i_valid is accepted at the next IDLE cycle.
REQ-023 SHALL not let changes to i_data after acceptance affect the frame in flight.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, set state=IDLE, counters=0, o_tx=1, o_ready=1 (from the following cycle) and o_busy=0.
REQ-025 SHALL, when rst is asserted mid-frame, abandon the frame with no stop bit emitted and drive o_tx=1 after the next edge.
REQ-026 SHALL, when rst and i_valid=1 occur in the same cycle, give rst priority and accept no word.

Configuration
REQ-027 SHALL, with ODD_PARITY_SERIAL_TX_INJECT_EN defined, latch i_inject at acceptance and transmit the inverted parity bit when it is 1; the rest of the frame is unchanged.
REQ-028 SHALL, without ODD_PARITY_SERIAL_TX_INJECT_EN, omit port i_inject and always transmit correct odd parity.

Verification (width=8, divisor=4)
REQ-029 SHALL cover: send 0xA5 -> o_tx bits 0,1,0,1,0,0,1,0,1,1,1, each 4 cycles, 44 cycles total; an odd-parity checker reports no error.
REQ-030 SHALL cover: send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; send 0xFF -> parity bit 1.
REQ-031 SHALL cover: i_valid held high with 0x12 then 0x34 -> second start bit begins 45 cycles after the first, one idle-high cycle between frames; i_data changes during frame 1 have no effect.
REQ-032 SHALL cover: rst pulsed during DATA bit 3 -> o_tx=1 and o_ready=1 after reset; the next word 0x55 transmits a complete, correct frame.
REQ-033 SHALL cover, with INJECT_EN: send 0xA5 with i_inject=1 -> parity bit 0, the checker flags an error, and a following frame sent with i_inject=0 is correct.
